// File: rtl/face_erode.sv
// 3x3 binary erosion between skin binarisation and the bounding-box stage.
// Optional macro FACE_PIXCNT_EN adds pix_cnt, a per-frame eroded-foreground count.
module face_erode #(
   parameter logic [11:0] H_DISP = 12'd480,
   parameter logic [11:0] V_DISP = 12'd272
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        face_hsync,
   input  logic        face_vsync,
   input  logic [7:0]  face_data,
   input  logic        face_de,
   output logic        ero_hsync,
   output logic        ero_vsync,
   output logic [7:0]  ero_data,
   output logic        ero_de
`ifdef FACE_PIXCNT_EN
   ,
   output logic [18:0] pix_cnt
`endif
);

   logic [11:0]       r_col;
   logic [11:0]       r_row;
   logic              r_wr_done;
   logic [H_DISP-1:0] r_lb1;
   logic [H_DISP-1:0] r_lb2;
   logic [2:0]        r_win_c1;
   logic [2:0]        r_win_c0;
   logic              r_e;
   logic              r_hs_d1;
   logic              r_vs_d1;
   logic              r_de_d1;

   logic              w_b;
   logic              w_r1;
   logic              w_r2;
   logic              w_de_fall;
   logic              w_vs_rise;
   logic              w_wr;
   logic              w_e;

   assign w_b       = |face_data;
   assign w_de_fall = r_de_d1 & ~face_de;
   assign w_vs_rise = face_vsync & ~r_vs_d1;
   assign w_wr      = face_de & ~r_wr_done;

   // Line-buffer read at the current column: r2 = row y-2, r1 = row y-1
   always_comb begin
      w_r1 = 1'b0;
      w_r2 = 1'b0;
      for (int i = 0; i < int'(H_DISP); i++) begin
         if (r_col == 12'(i)) begin
            w_r1 = r_lb1[i];
            w_r2 = r_lb2[i];
         end else begin
            w_r1 = w_r1;
            w_r2 = w_r2;
         end
      end
   end

   // Erosion of the two held columns plus the incoming one, masked at the top/left borders
   always_comb begin
      if ((r_row >= 12'd2) && (r_col >= 12'd2)) begin
         w_e = &{r_win_c1, r_win_c0, w_r2, w_r1, w_b};
      end else begin
         w_e = 1'b0;
      end
   end

   // Column/row counters and the once-per-line saturation flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col     <= 12'd0;
         r_row     <= 12'd0;
         r_wr_done <= 1'b0;
      end else begin
         if (face_de) begin
            if (r_col != H_DISP - 12'd1) begin
               r_col <= r_col + 12'd1;
            end else begin
               r_wr_done <= 1'b1;
            end
         end else if (w_de_fall) begin
            r_col     <= 12'd0;
            r_wr_done <= 1'b0;
         end
         if (w_vs_rise) begin
            r_row <= 12'd0;
         end else if (w_de_fall && (r_row != V_DISP - 12'd1)) begin
            r_row <= r_row + 12'd1;
         end
      end
   end

   // Line buffers shift one row down at the current column
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lb1 <= '0;
         r_lb2 <= '0;
      end else begin
         for (int i = 0; i < int'(H_DISP); i++) begin
            if (w_wr && (r_col == 12'(i))) begin
               r_lb2[i] <= r_lb1[i];
               r_lb1[i] <= w_b;
            end
         end
      end
   end

   // Window holds the two previous column vectors; stage-1 erosion and sync delay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_c1 <= 3'd0;
         r_win_c0 <= 3'd0;
         r_e      <= 1'b0;
         r_hs_d1  <= 1'b0;
         r_vs_d1  <= 1'b0;
         r_de_d1  <= 1'b0;
      end else begin
         if (face_de) begin
            r_win_c1 <= r_win_c0;
            r_win_c0 <= {w_r2, w_r1, w_b};
         end
         r_e     <= face_de & w_e;
         r_hs_d1 <= face_hsync;
         r_vs_d1 <= face_vsync;
         r_de_d1 <= face_de;
      end
   end

   // Output stage: second delay tap and byte expansion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ero_hsync <= 1'b0;
         ero_vsync <= 1'b0;
         ero_de    <= 1'b0;
         ero_data  <= 8'h00;
      end else begin
         ero_hsync <= r_hs_d1;
         ero_vsync <= r_vs_d1;
         ero_de    <= r_de_d1;
         ero_data  <= (r_e & r_de_d1) ? 8'hFF : 8'h00;
      end
   end

`ifdef FACE_PIXCNT_EN
   logic [18:0] r_pix_acc;

   // Per-frame foreground count, published at each frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_acc <= 19'd0;
         pix_cnt   <= 19'd0;
      end else if (w_vs_rise) begin
         pix_cnt   <= r_pix_acc;
         r_pix_acc <= 19'd0;
      end else if (face_de && w_e && (r_pix_acc != 19'h7FFFF)) begin
         r_pix_acc <= r_pix_acc + 19'd1;
      end
   end
`endif

endmodule

// File: tb/tb_face_erode.sv
// Randomised self-checking bench for face_erode on an 8x6 frame.
module tb_face_erode;
   localparam int HD = 8;
   localparam int VD = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       face_hsync, face_vsync, face_de;
   logic [7:0] face_data;
   logic       ero_hsync, ero_vsync, ero_de;
   logic [7:0] ero_data;
`ifdef FACE_PIXCNT_EN
   logic [18:0] pix_cnt;
`endif

   always #5 clk = ~clk;

   face_erode #(.H_DISP(12'd8), .V_DISP(12'd6)) dut (
      .clk(clk), .rst(rst),
      .face_hsync(face_hsync), .face_vsync(face_vsync),
      .face_data(face_data), .face_de(face_de),
      .ero_hsync(ero_hsync), .ero_vsync(ero_vsync),
      .ero_data(ero_data), .ero_de(ero_de)
`ifdef FACE_PIXCNT_EN
      , .pix_cnt(pix_cnt)
`endif
   );

   int         n_chk = 0;
   int         n_fail = 0;
   int         ones_obs;
   int         last_cnt = 0;
   bit         cnt_ok = 1'b1;
   bit         chk_en = 1'b1;
   logic [7:0] pix [VD][HD];
   // expected-output history: {valid, hs, vs, de, data}
   logic [11:0] p1 = 12'd0;
   logic [11:0] p2 = 12'd0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Erosion reference: output (x,y) is 1 iff every input in rows y-2..y, cols x-2..x is nonzero
   function automatic logic ref_out(int x, int y);
      if (x < 2 || y < 2) return 1'b0;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++)
            if (pix[y-dy][x-dx] == 8'h00) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic hs, input logic vs, input logic de,
                       input logic [7:0] d, input logic [7:0] ed);
      face_hsync = hs;
      face_vsync = vs;
      face_de    = de;
      face_data  = d;
      @(posedge clk);
      p2 = p1;
      p1 = {1'b1, hs, vs, de, ed};
      @(negedge clk);
      if (chk_en && p2[11]) begin
         check_val("ero_hsync", 32'(ero_hsync), 32'(p2[10]));
         check_val("ero_vsync", 32'(ero_vsync), 32'(p2[9]));
         check_val("ero_de",    32'(ero_de),    32'(p2[8]));
         check_val("ero_data",  32'(ero_data),  32'(p2[7:0]));
         if (ero_data == 8'hFF) ones_obs++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_val("rst_async_data",  32'(ero_data),  32'd0);
      check_val("rst_async_de",    32'(ero_de),    32'd0);
      check_val("rst_async_hsync", 32'(ero_hsync), 32'd0);
      check_val("rst_async_vsync", 32'(ero_vsync), 32'd0);
      chk_en = 1'b0;
      p1 = 12'd0;
      p2 = 12'd0;
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      rst = 1'b0;
   endtask

   task automatic run_frame(input string name, input int rst_row);
      int   exp_ones;
      logic e;
      exp_ones = 0;
      ones_obs = 0;
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef FACE_PIXCNT_EN
      if (cnt_ok) check_val({name, " pix_cnt"}, 32'(pix_cnt), 32'(last_cnt));
`endif
      for (int y = 0; y < VD; y++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
         step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         for (int x = 0; x < HD; x++) begin
            if (y == rst_row && x == 5) do_reset();
            e = ref_out(x, y);
            if (e) exp_ones++;
            step(1'b0, 1'b0, 1'b1, pix[y][x], e ? 8'hFF : 8'h00);
         end
         for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (chk_en) check_val({name, " ones"}, 32'(ones_obs), 32'(exp_ones));
      last_cnt = exp_ones;
      cnt_ok   = chk_en;
      chk_en   = 1'b1;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int y = 0; y < VD; y++)
         for (int x = 0; x < HD; x++)
            pix[y][x] = v;
   endtask

   initial begin
      rst        = 1'b1;
      face_hsync = 1'b0;
      face_vsync = 1'b0;
      face_de    = 1'b0;
      face_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset ero_data",  32'(ero_data),  32'd0);
      check_val("reset ero_de",    32'(ero_de),    32'd0);
      check_val("reset ero_hsync", 32'(ero_hsync), 32'd0);
      check_val("reset ero_vsync", 32'(ero_vsync), 32'd0);
      rst = 1'b0;

      fill(8'hFF);
      run_frame("all_ff", -1);

      fill(8'h00);
      pix[3][4] = 8'hFF;
      run_frame("single", -1);

      fill(8'h00);
      for (int y = 1; y <= 3; y++)
         for (int x = 2; x <= 4; x++)
            pix[y][x] = 8'hFF;
      run_frame("block", -1);

      fill(8'hFF);
      run_frame("rst_mid", 3);
      run_frame("after_rst", -1);

      fill(8'h01);
      run_frame("all_01", -1);

      for (int f = 0; f < 4; f++) begin
         for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
               pix[y][x] = ($urandom_range(0, 7) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame("random", -1);
      end

      fill(8'hFF);
      run_frame("final", -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
